button_input_bank: RTL and testbench
====================================

# button_input_bank

Parametrised multi-channel button front end that replaces the per-button debouncer instances at the top level. Each of `N_CH` raw button inputs is synchronised, debounced with a programmable stable-time, and turned into single-cycle press/release pulses. It also adds two behaviours the single debouncer lacks: a long-press pulse and an auto-repeat pulse train while a button is held. Outputs feed the text-select, display-update and LCD send logic directly as one-cycle triggers.

## Interface
- `N_CH`, 4, number of button channels (1..16)
- `ACTIVE_LOW`, 1, 1 = raw input low means pressed; 0 = high means pressed
- `DEB_CYCLES`, 250000, stable cycles required before a level change is accepted (>= 2)
- `DEB_W`, 18, debounce counter width; must hold `DEB_CYCLES-1`
- `LONG_CYCLES`, 25000000, held cycles after press before `long_press` pulse (>= 2)
- `REPEAT_CYCLES`, 5000000, period of `repeat` pulses after long press; 0 disables repeat
- `HOLD_W`, 25, hold/repeat counter width; must hold `max(LONG_CYCLES, REPEAT_CYCLES)-1`

- `CLK` in 1 system clock; all logic on rising edge
- `RST` in 1 synchronous, active-high reset
- `buttons` in N_CH raw asynchronous button levels
- `pressed` out N_CH debounced level per channel, 1 = pressed
- `press` out N_CH one-cycle pulse on accepted released→pressed change
- `release` out N_CH one-cycle pulse on accepted pressed→released change
- `long_press` out N_CH one-cycle pulse, once per hold, after `LONG_CYCLES`
- `repeat` out N_CH one-cycle pulse every `REPEAT_CYCLES` after `long_press` while held
- `any_pressed` out 1 OR of `pressed`

## Operation
Per channel, fully independent; no shared state except `any_pressed`.
- Sync: two flops on `buttons[i]`, then polarity-normalised so internal `s` = 1 means pressed.
- Debounce: registers `stable`, `dcnt[DEB_W-1:0]`.
  - `s == stable`: `dcnt <= 0`.
  - `s != stable` and `dcnt < DEB_CYCLES-1`: `dcnt <= dcnt+1`.
  - `s != stable` and `dcnt == DEB_CYCLES-1`: `stable <= s`, `dcnt <= 0`, pulse `press` (if s=1) or `release` (if s=0) registered at the same edge.
  - Any glitch back to `stable` level restarts count from 0.
- Hold FSM, states IDLE, HOLD, REPEAT:
  - IDLE: `hcnt <= 0`; on the edge that sets `stable` to 1 → HOLD.
  - HOLD: `hcnt` increments; when `hcnt == LONG_CYCLES-1`, pulse `long_press`, `hcnt <= 0`, → REPEAT if `REPEAT_CYCLES != 0`, else stay in a terminal held condition (REPEAT with no pulses).
  - REPEAT: `hcnt` increments; when `hcnt == REPEAT_CYCLES-1`, pulse `repeat`, `hcnt <= 0`.
  - Any state: edge that clears `stable` → IDLE, `hcnt <= 0`; `long_press`/`repeat` not issued on that edge.
- `pressed = stable`; `any_pressed` is registered OR of `stable` next-state (aligned with `pressed`).
- Counters never wrap: every count ends at compare-and-clear.

## Timing
- Reset (edge with `RST`=1): sync flops load released level, `stable`=0, `dcnt`=0, `hcnt`=0, FSM IDLE; all outputs 0 the cycle after. Reset mid-press drops `pressed` with no `release` pulse; a still-held button re-debounces from 0 after reset deasserts and then produces `press`.
- Press latency: raw level held stable from sample edge E → `press` and `pressed` high after edge E+1+`DEB_CYCLES` (2 sync stages, `DEB_CYCLES` count edges).
- `long_press` after edge `LONG_CYCLES` following the `press` edge; first `repeat` `REPEAT_CYCLES` edges after that, then periodic.
- `press`, `release`, `long_press`, `repeat` each high exactly one cycle; `press` and `release` never coincide on one channel.
- Simultaneous events on different channels all reported in the same cycle.
- Release on the same edge `hcnt` would hit a compare: release wins, no long/repeat pulse.

## Test plan
Params N_CH=4, ACTIVE_LOW=1, DEB_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3.
- Reset with `buttons`=4'hF → all outputs 0; hold 20 cycles → no pulses.
- `buttons[0]` 1→0 held → `press[0]` one cycle exactly 5 edges after sample; `pressed[0]`=1, `any_pressed`=1.
- `buttons[1]` bounces 0/1 every 2 cycles for 30 cycles, then held 0 → no pulse during bounce; single `press[1]` 5 edges after final settle.
- Hold ch0 → `long_press[0]` 10 edges after `press[0]`; `repeat[0]` at +3, +6, +9; release → `release[0]` after debounce, no further repeats.
- Ch2 and ch3 pressed same cycle → `press[3:2]`=2'b11 same cycle; release ch3 on the edge `long_press[3]` due → `long_press[3]` never asserted.
- REPEAT_CYCLES=0 build, hold 40 cycles → one `long_press`, zero `repeat`; assert `RST` mid-hold → `pressed`=0, no `release`, re-press after 5 edges.

Source files
------------

// File: rtl/button_input_bank.sv
// ---------------------------------------------------------------------------
// ButtonInputBank: multi-channel button front end.
//
// Each raw button input is synchronised through two flops and normalised so
// that 1 means pressed. It is then debounced with a programmable stable time
// and turned into one-cycle press/release pulses. While a button is held, a
// small per-channel FSM issues a single long-press pulse and then an
// auto-repeat pulse train.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous, active-high reset
//   i_buttons      raw asynchronous button levels (N_CH bits)
//   o_pressed      debounced level per channel, 1 = pressed
//   o_press        one-cycle pulse on an accepted released->pressed change
//   o_release      one-cycle pulse on an accepted pressed->released change
//   o_long_press   one-cycle pulse, once per hold, LONG_CYCLES after press
//   o_repeat       one-cycle pulse every REPEAT_CYCLES after the long press
//   o_any_pressed  OR of o_pressed
// ---------------------------------------------------------------------------
module button_input_bank #(
  parameter int N_CH          = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 250000,
  parameter int DEB_W         = 18,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int HOLD_W        = 25
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_buttons,
  output logic [N_CH-1:0] o_pressed,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long_press,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any_pressed
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } holdState_t;

  // Raw level that corresponds to "released"; the sync flops reset to it so
  // that leaving reset never looks like a press.
  localparam logic RelRaw = (ACTIVE_LOW != 0);

  localparam logic [DEB_W-1:0]  DebLast  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LongLast = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] RepLast  =
    (REPEAT_CYCLES == 0) ? '0 : HOLD_W'(REPEAT_CYCLES - 1);

  logic [N_CH-1:0]   r_sync1;
  logic [N_CH-1:0]   r_sync2;
  logic [N_CH-1:0]   r_stable;
  logic [DEB_W-1:0]  r_dcnt [N_CH];
  logic [HOLD_W-1:0] r_hcnt [N_CH];
  holdState_t        r_state [N_CH];
  logic [N_CH-1:0]   r_press;
  logic [N_CH-1:0]   r_release;
  logic [N_CH-1:0]   r_long;
  logic [N_CH-1:0]   r_repeat;
  logic              r_any;

  logic [N_CH-1:0]   w_s;
  logic [N_CH-1:0]   w_accept;
  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_fall;
  logic [N_CH-1:0]   w_stableNext;

  // Normalise polarity and decide, per channel, whether this edge accepts a
  // level change (the debounce count has run out while the input still
  // differs from the accepted level).
  always_comb begin
    w_s      = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    w_accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_accept[i] = (w_s[i] != r_stable[i]) && (r_dcnt[i] == DebLast);
    end
    w_rise       = w_accept & w_s;
    w_fall       = w_accept & ~w_s;
    w_stableNext = r_stable ^ w_accept;
  end

  // Synchroniser, debounce counters, edge pulses and the hold FSM. A falling
  // accept always wins over a hold/repeat compare landing on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= {N_CH{RelRaw}};
      r_sync2   <= {N_CH{RelRaw}};
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_repeat  <= '0;
      r_any     <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_dcnt[i]  <= '0;
        r_hcnt[i]  <= '0;
        r_state[i] <= ST_IDLE;
      end
    end else begin
      r_sync1   <= i_buttons;
      r_sync2   <= r_sync1;
      r_stable  <= w_stableNext;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_any     <= |w_stableNext;
      for (int i = 0; i < N_CH; i++) begin
        // Any return to the accepted level restarts the stable-time count.
        if ((w_s[i] == r_stable[i]) || w_accept[i]) begin
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end

        r_long[i]   <= 1'b0;
        r_repeat[i] <= 1'b0;
        if (w_fall[i]) begin
          r_state[i] <= ST_IDLE;
          r_hcnt[i]  <= '0;
        end else begin
          case (r_state[i])
            ST_IDLE: begin
              r_hcnt[i] <= '0;
              if (w_rise[i]) begin
                r_state[i] <= ST_HOLD;
              end
            end
            ST_HOLD: begin
              if (r_hcnt[i] == LongLast) begin
                r_long[i]  <= 1'b1;
                r_hcnt[i]  <= '0;
                r_state[i] <= ST_REPEAT;
              end else begin
                r_hcnt[i] <= r_hcnt[i] + 1'b1;
              end
            end
            ST_REPEAT: begin
              // With repeat disabled this is a silent terminal held state.
              if (REPEAT_CYCLES == 0) begin
                r_hcnt[i] <= '0;
              end else if (r_hcnt[i] == RepLast) begin
                r_repeat[i] <= 1'b1;
                r_hcnt[i]   <= '0;
              end else begin
                r_hcnt[i] <= r_hcnt[i] + 1'b1;
              end
            end
            default: begin
              r_state[i] <= ST_IDLE;
              r_hcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign o_pressed     = r_stable;
  assign o_press       = r_press;
  assign o_release     = r_release;
  assign o_long_press  = r_long;
  assign o_repeat      = r_repeat;
  assign o_any_pressed = r_any;

endmodule

// File: tb/tb_button_input_bank.sv
// ---------------------------------------------------------------------------
// Testbench for button_input_bank. Two instances: bank A with auto-repeat
// (REPEAT_CYCLES=3) and bank B with repeat disabled (REPEAT_CYCLES=0). Both
// use active-low buttons, DEB_CYCLES=4 and LONG_CYCLES=10. Directed vectors,
// with expected pulse positions counted in clock edges after the input change.
// ---------------------------------------------------------------------------
module tb_button_input_bank;

  logic       clk;
  logic       rstA;
  logic       rstB;
  logic [3:0] btnA;
  logic [3:0] btnB;

  logic [3:0] pressedA, pressA, releaseA, longA, repeatA;
  logic       anyA;
  logic [3:0] pressedB, pressB, releaseB, longB, repeatB;
  logic       anyB;

  int compareCount  = 0;
  int mismatchCount = 0;

  button_input_bank #(
    .N_CH(4), .ACTIVE_LOW(1), .DEB_CYCLES(4), .DEB_W(18),
    .LONG_CYCLES(10), .REPEAT_CYCLES(3), .HOLD_W(25)
  ) dutA (
    .i_clk(clk), .i_rst(rstA), .i_buttons(btnA),
    .o_pressed(pressedA), .o_press(pressA), .o_release(releaseA),
    .o_long_press(longA), .o_repeat(repeatA), .o_any_pressed(anyA)
  );

  button_input_bank #(
    .N_CH(4), .ACTIVE_LOW(1), .DEB_CYCLES(4), .DEB_W(18),
    .LONG_CYCLES(10), .REPEAT_CYCLES(0), .HOLD_W(25)
  ) dutB (
    .i_clk(clk), .i_rst(rstB), .i_buttons(btnB),
    .o_pressed(pressedB), .o_press(pressB), .o_release(releaseB),
    .o_long_press(longB), .o_repeat(repeatB), .o_any_pressed(anyB)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle, so outputs are sampled 1 unit after.
  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  // Drive both banks' raw button levels.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    btnA = a;
    btnB = b;
  endtask

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(4'hF, 4'hF);
    stepClock;
    stepClock;
    checkOutput("reset A outputs",
                {pressedA, pressA, releaseA, longA, repeatA, anyA}, 0);
    checkOutput("reset B outputs",
                {pressedB, pressB, releaseB, longB, repeatB, anyB}, 0);
    rstA = 1'b0;
    rstB = 1'b0;

    // Idle with all buttons released: nothing may happen.
    for (int t = 1; t <= 20; t++) begin
      stepClock;
      checkOutput($sformatf("idle A t=%0d", t),
                  {pressedA, pressA, releaseA, longA, repeatA, anyA}, 0);
    end

    // Channel 0 press and hold: press at edge 6, long at 16, repeats every 3.
    applyStimulus(4'b1110, 4'hF);
    for (int k = 1; k <= 26; k++) begin
      stepClock;
      checkOutput($sformatf("press0 k=%0d", k), pressA[0], (k == 6));
      checkOutput($sformatf("long0 k=%0d", k), longA[0], (k == 16));
      checkOutput($sformatf("repeat0 k=%0d", k), repeatA[0],
                  (k == 19) || (k == 22) || (k == 25));
      checkOutput($sformatf("release0 held k=%0d", k), releaseA[0], 0);
      if (k == 6) begin
        checkOutput("pressed0 at press", pressedA[0], 1);
        checkOutput("any at press", anyA, 1);
      end
    end

    // Release channel 0: release pulse after debounce, then no repeats.
    applyStimulus(4'hF, 4'hF);
    for (int t = 1; t <= 12; t++) begin
      stepClock;
      checkOutput($sformatf("release0 t=%0d", t), releaseA[0], (t == 6));
      checkOutput($sformatf("pressed0 rel t=%0d", t), pressedA[0], (t < 6));
      checkOutput($sformatf("any rel t=%0d", t), anyA, (t < 6));
      if (t >= 6) begin
        checkOutput($sformatf("repeat0 after rel t=%0d", t), repeatA[0], 0);
      end
    end

    // Channel 1 bounces in 2-cycle runs: never stable long enough to accept.
    for (int t = 0; t < 30; t++) begin
      applyStimulus({2'b11, ((t / 2) % 2 == 0), 1'b1}, 4'hF);
      stepClock;
      checkOutput($sformatf("bounce1 t=%0d", t), {pressedA[1], pressA[1]}, 0);
    end
    applyStimulus(4'b1101, 4'hF);
    for (int t = 1; t <= 7; t++) begin
      stepClock;
      checkOutput($sformatf("press1 t=%0d", t), pressA[1], (t == 6));
      checkOutput($sformatf("pressed1 t=%0d", t), pressedA[1], (t >= 6));
    end
    applyStimulus(4'hF, 4'hF);
    for (int t = 1; t <= 7; t++) begin
      stepClock;
      checkOutput($sformatf("release1 t=%0d", t), releaseA[1], (t == 6));
    end

    // Channels 2 and 3 together; ch3 released so its accept lands on the
    // edge its long press would fire, ch2 held to show that edge was due.
    applyStimulus(4'b0011, 4'hF);
    for (int t = 1; t <= 6; t++) begin
      stepClock;
      checkOutput($sformatf("press32 t=%0d", t), pressA[3:2],
                  (t == 6) ? 2'b11 : 2'b00);
    end
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) applyStimulus(4'b1011, 4'hF);
      stepClock;
      checkOutput($sformatf("long3 k=%0d", k), longA[3], 0);
      checkOutput($sformatf("release3 k=%0d", k), releaseA[3], (k == 10));
      checkOutput($sformatf("long2 k=%0d", k), longA[2], (k == 10));
    end
    applyStimulus(4'hF, 4'hF);
    for (int t = 1; t <= 8; t++) stepClock;

    // Bank B: repeat disabled, one long press and nothing after it.
    applyStimulus(4'hF, 4'b1110);
    for (int k = 1; k <= 40; k++) begin
      stepClock;
      checkOutput($sformatf("B press0 k=%0d", k), pressB[0], (k == 6));
      checkOutput($sformatf("B long0 k=%0d", k), longB[0], (k == 16));
      checkOutput($sformatf("B repeat k=%0d", k), repeatB, 0);
    end

    // Reset mid-hold: level drops silently, then the held button re-presses.
    rstB = 1'b1;
    stepClock;
    checkOutput("B pressed in reset", pressedB, 0);
    checkOutput("B release in reset", releaseB, 0);
    checkOutput("B any in reset", anyB, 0);
    rstB = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      stepClock;
      checkOutput($sformatf("B release0 re k=%0d", k), releaseB[0], 0);
      checkOutput($sformatf("B press0 re k=%0d", k), pressB[0], (k == 6));
      checkOutput($sformatf("B pressed0 re k=%0d", k), pressedB[0], (k >= 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, mismatchCount);
    $finish;
  end

endmodule
